// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central hazard controller for the RV32I 5-stage pipeline. It resolves
// data-memory waits (freeze), taken-branch flushes and load-use stalls in
// that priority order. It also produces the EX operand forwarding selects
// and keeps saturating stall/flush counters plus a sticky timeout error.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   id_rs1/rs2, id_uses_rs1/rs2      ID-stage source registers and usage
//   ex_rs1/rs2, ex_rd                EX-stage sources / destination
//   ex_load, ex_reg_write            EX instruction is a load / writes RF
//   mem_rd, mem_load, mem_reg_write  MEM-stage destination and kind
//   wb_rd, wb_reg_write              WB-stage destination and write flag
//   ex_branch_taken                  EX redirects the PC
//   mem_req, dmem_ready              data-memory handshake
//   pc_en, *_en                      pipeline register load enables
//   if_id_flush, id_ex_flush         load a bubble on the next edge
//   fwd_a_sel, fwd_b_sel             00 RF, 01 EX/MEM, 10 MEM/WB
//   mem_err                          sticky memory-timeout error
//   stall_cycles, flush_count        saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_load,
  input  logic             ex_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic             mem_load,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_MEM_WAIT = 2'b01,
    S_ERR      = 2'b10
  } state_t;

  // Wait counter must be able to hold MEM_TIMEOUT itself.
  localparam int                WCNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]   flush_count_q, flush_count_d;
  logic               mem_err_q, mem_err_d;

  logic               freeze_s;
  logic               load_use_s;
  logic               branch_fire_s;

  // Forward select for one EX source; EX/MEM beats MEM/WB, x0 never forwarded.
  // Loads in MEM have no ALU result to forward, so they are skipped there.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] m_rd,
    input logic       m_wr,
    input logic       m_ld,
    input logic [4:0] w_rd,
    input logic       w_wr
  );
    logic [1:0] sel;
    if (m_wr && !m_ld && (m_rd != 5'd0) && (m_rd == rs)) begin
      sel = 2'b01;
    end else if (w_wr && (w_rd != 5'd0) && (w_rd == rs)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Hazard conditions; ERR is not frozen here since it is handled as its own state.
  always_comb begin
    freeze_s   = (state_q != S_ERR) && mem_req && !dmem_ready;
    load_use_s = ex_load && ex_reg_write && (ex_rd != 5'd0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_rd)));
    // A branch held through a freeze fires (and is counted) on the release cycle.
    branch_fire_s = rst_n && (state_q != S_ERR) && !freeze_s && ex_branch_taken;
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_RUN: begin
        if (freeze_s) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end else begin
          wait_cnt_d = '0;
        end
      end
      S_MEM_WAIT: begin
        if (freeze_s) begin
          if (wait_cnt_q == WCNT_MAX) begin
            state_d = S_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + WCNT_W'(1);
          end
        end else begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Mealy control outputs: freeze > branch > load-use > default.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    ex_mem_en   = 1'b1;
    mem_wb_en   = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst_n) begin
      // Pipeline fills with bubbles while reset is held.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      case (state_q)
        S_RUN, S_MEM_WAIT: begin
          if (freeze_s) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
          end else if (branch_fire_s) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use_s) begin
            // Hold PC and IF/ID, inject one bubble into ID/EX.
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end else begin
            pc_en = 1'b1;
          end
        end
        default: begin
          // ERR (and any illegal encoding) keeps the pipeline frozen.
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end
      endcase
    end
  end

  // Forwarding selects for both EX operands.
  always_comb begin
    fwd_a_sel = fwd_sel(ex_rs1, mem_rd, mem_reg_write, mem_load, wb_rd, wb_reg_write);
    fwd_b_sel = fwd_sel(ex_rs2, mem_rd, mem_reg_write, mem_load, wb_rd, wb_reg_write);
  end

  // Saturating counters and sticky error.
  always_comb begin
    if (!pc_en && (stall_cycles_q != CNT_SAT)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    if (branch_fire_s && (flush_count_q != CNT_SAT)) begin
      flush_count_d = flush_count_q + CNT_W'(1);
    end else begin
      flush_count_d = flush_count_q;
    end
    mem_err_d = mem_err_q || (state_d == S_ERR);
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      wait_cnt_q     <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
      mem_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
      mem_err_q      <= mem_err_d;
    end
  end

  assign mem_err      = mem_err_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed
// by randomized traffic, all compared against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int T   = 4;
  localparam int CW  = 5;
  localparam int SAT = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [4:0]    id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_load, ex_reg_write;
  logic          mem_load, mem_reg_write, wb_reg_write;
  logic          ex_branch_taken, mem_req, dmem_ready;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, mem_err;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cycles, flush_count;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: consecutive frozen cycles, error flag, counters.
  int m_wait  = 0;
  bit m_err   = 1'b0;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_load(ex_load), .ex_reg_write(ex_reg_write),
    .mem_rd(mem_rd), .mem_load(mem_load), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_err(mem_err), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source that the EX operand should read, by scanning younger-to-older stages.
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return 2'b00;
    if (mem_reg_write && !mem_load && mem_rd == rs) return 2'b01;
    if (wb_reg_write && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  // Called at a negedge with inputs applied: checks outputs, then advances the model.
  task automatic cycle_check(input string tag);
    logic [6:0] exp_ctrl;
    bit frozen, lu;
    #1;
    frozen = !m_err && mem_req && !dmem_ready;
    lu = ex_load && ex_reg_write && ex_rd != 5'd0 &&
         ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    // order: pc, if_id, id_ex, ex_mem, mem_wb enables, if_id_flush, id_ex_flush
    if (!rst_n)                exp_ctrl = 7'b1111111;
    else if (m_err || frozen)  exp_ctrl = 7'b0000000;
    else if (ex_branch_taken)  exp_ctrl = 7'b1111111;
    else if (lu)               exp_ctrl = 7'b0011101;
    else                       exp_ctrl = 7'b1111100;
    check_val({tag, "_ctrl"},
              {25'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush},
              {25'd0, exp_ctrl});
    check_val({tag, "_fwd_a"}, {30'd0, fwd_a_sel}, {30'd0, ref_fwd(ex_rs1)});
    check_val({tag, "_fwd_b"}, {30'd0, fwd_b_sel}, {30'd0, ref_fwd(ex_rs2)});
    check_val({tag, "_mem_err"}, {31'd0, mem_err}, {31'd0, m_err});
    check_val({tag, "_stall_cnt"}, {{(32-CW){1'b0}}, stall_cycles}, m_stall);
    check_val({tag, "_flush_cnt"}, {{(32-CW){1'b0}}, flush_count}, m_flush);
    if (!rst_n) begin
      m_wait = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end else begin
      if (!exp_ctrl[6]) m_stall = sat_inc(m_stall);
      if (ex_branch_taken && !frozen && !m_err) m_flush = sat_inc(m_flush);
      if (!m_err) begin
        if (frozen) begin
          m_wait++;
          // The access may wait T cycles; the next frozen cycle is an error.
          if (m_wait == T + 1) m_err = 1'b1;
        end else begin
          m_wait = 0;
        end
      end
    end
  endtask

  task automatic tick(input string tag);
    cycle_check(tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_load = 1'b0; ex_reg_write = 1'b0;
    mem_rd = 5'd0; mem_load = 1'b0; mem_reg_write = 1'b0;
    wb_rd = 5'd0; wb_reg_write = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  task automatic reset_pulse();
    idle_inputs();
    rst_n = 1'b0;
    tick("rst");
    rst_n = 1'b1;
  endtask

  task automatic setup_load_use();
    ex_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_rs2 = 5'd1; id_uses_rs1 = 1'b1; id_uses_rs2 = 1'b1;
  endtask

  int burst = 0;

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);

    // Reset state
    cycle_check("reset");
    check_val("reset_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick("idle");

    // Load-use: lw x5 in EX, add x6,x5,x1 in ID
    setup_load_use();
    cycle_check("lu");
    check_val("lu_pc_en", {31'd0, pc_en}, 32'd0);
    check_val("lu_ex_mem_en", {31'd0, ex_mem_en}, 32'd1);
    @(negedge clk);
    idle_inputs();
    mem_load = 1'b1; mem_reg_write = 1'b1; mem_rd = 5'd5;
    id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
    tick("lu_after");
    check_val("lu_stall_total", {{(32-CW){1'b0}}, stall_cycles}, 32'd1);
    idle_inputs();
    setup_load_use();
    ex_rd = 5'd0; id_rs1 = 5'd0;
    cycle_check("lu_x0");
    check_val("lu_x0_pc_en", {31'd0, pc_en}, 32'd1);
    @(negedge clk);

    // Forwarding priority
    idle_inputs();
    mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
    ex_rs1 = 5'd7; ex_rs2 = 5'd0;
    cycle_check("fwd_mem");
    check_val("fwd_a_exmem", {30'd0, fwd_a_sel}, 32'd1);
    check_val("fwd_b_x0", {30'd0, fwd_b_sel}, 32'd0);
    @(negedge clk);
    mem_load = 1'b1;
    cycle_check("fwd_wb");
    check_val("fwd_a_memwb", {30'd0, fwd_a_sel}, 32'd2);
    @(negedge clk);

    // Memory wait of 3 cycles
    reset_pulse();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick("mwait");
    dmem_ready = 1'b1;
    cycle_check("mwait_release");
    check_val("mwait_release_mem_wb_en", {31'd0, mem_wb_en}, 32'd1);
    @(negedge clk);
    check_val("mwait_stall_total", {{(32-CW){1'b0}}, stall_cycles}, 32'd3);
    mem_req = 1'b0;
    tick("mwait_run");

    // Timeout into ERR, held long enough to saturate stall_cycles
    reset_pulse();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < T + 1; i++) tick("tmo");
    check_val("tmo_mem_err", {31'd0, mem_err}, 32'd1);
    dmem_ready = 1'b1; mem_req = 1'b0;
    for (int i = 0; i < 30; i++) tick("err_hold");
    check_val("err_stall_sat", {{(32-CW){1'b0}}, stall_cycles}, SAT);
    reset_pulse();
    check_val("err_cleared", {31'd0, mem_err}, 32'd0);
    tick("post_err");

    // Branch and load-use together
    setup_load_use();
    ex_branch_taken = 1'b1;
    cycle_check("br_lu");
    check_val("br_lu_pc_en", {31'd0, pc_en}, 32'd1);
    @(negedge clk);
    check_val("br_lu_flush_cnt", {{(32-CW){1'b0}}, flush_count}, 32'd1);
    check_val("br_lu_stall_cnt", {{(32-CW){1'b0}}, stall_cycles}, 32'd0);

    // Branch held during a 2-cycle freeze
    reset_pulse();
    ex_branch_taken = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) tick("br_frz");
    dmem_ready = 1'b1;
    cycle_check("br_release");
    check_val("br_release_if_id_flush", {31'd0, if_id_flush}, 32'd1);
    @(negedge clk);
    check_val("br_frz_flush_cnt", {{(32-CW){1'b0}}, flush_count}, 32'd1);

    // Reset during MEM_WAIT
    reset_pulse();
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) tick("rst_mw");
    rst_n = 1'b0;
    tick("rst_mw_hold");
    rst_n = 1'b1;
    for (int i = 0; i < T + 2; i++) tick("rst_mw_after");

    // Randomized traffic against the model
    reset_pulse();
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom);
      ex_load = 1'($urandom); ex_reg_write = 1'($urandom);
      mem_load = 1'($urandom); mem_reg_write = 1'($urandom);
      wb_reg_write = 1'($urandom);
      ex_branch_taken = ($urandom_range(0, 4) == 0);
      if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(1, 7);
      if (burst > 0) begin
        mem_req = 1'b1; dmem_ready = 1'b0; burst--;
      end else begin
        mem_req = ($urandom_range(0, 2) == 0);
        dmem_ready = ($urandom_range(0, 3) != 0);
      end
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the RV32I 5-stage pipeline. It drives the enables and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the PC enable. It resolves load-use stalls, taken-branch flushes and multi-cycle data-memory waits. It also generates the EX-stage operand forwarding selects and keeps performance and error counters.

Parameters:
MEM_TIMEOUT, 16, maximum consecutive cycles a data-memory access may wait for dmem_ready before an error is raised.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX.
ex_rd  in  5  destination register of the instruction in EX.
ex_load, ex_reg_write  in  1 each  the EX instruction is a load / writes the register file.
mem_rd  in  5  destination register of the instruction in MEM.
mem_load, mem_reg_write  in  1 each  the MEM instruction is a load / writes the register file.
wb_rd  in  5  destination register of the instruction in WB.
wb_reg_write  in  1  the WB instruction writes the register file.
ex_branch_taken  in  1  EX stage redirects the PC (branch taken, jal, jalr).
mem_req  in  1  EX/MEM register holds a memory access (mem_en).
dmem_ready  in  1  data memory completes the access this cycle.
pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
if_id_flush, id_ex_flush  out  1 each  load a bubble (NOP, all controls 0) on the next edge.
fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB writeback data.
mem_err  out  1  sticky memory-timeout error.
stall_cycles  out  CNT_W  cycles with pc_en=0.
flush_count  out  CNT_W  number of branch flushes.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. The FSM is registered. Control outputs are combinational from the state and the inputs (Mealy), so a stall applies in the same cycle its cause appears.
- Reset (rst_n=0 at an edge): state goes to RUN, the wait counter, stall_cycles and flush_count go to 0, and mem_err goes to 0.
- While rst_n=0, all *_en are 1 and both flushes are 1, so the pipeline fills with bubbles. Reset in the middle of MEM_WAIT or ERR returns the FSM to RUN.
- Memory freeze (highest priority): when the FSM is in RUN or MEM_WAIT with mem_req=1 and dmem_ready=0, all five enables are 0 and both flushes are 0.
  - RUN goes to MEM_WAIT, and the wait counter is set to 1.
  - In MEM_WAIT the counter increments each cycle.
  - If the counter equals MEM_TIMEOUT and dmem_ready is still 0, the FSM goes to ERR.
  - In the cycle dmem_ready=1, the enables resume and the FSM goes to RUN.
- ERR: all enables stay 0 and mem_err=1 until reset.
- Branch (second priority; evaluated only when not frozen): ex_branch_taken=1 gives if_id_flush=1, id_ex_flush=1 and all enables 1 (the PC loads the target). flush_count increments by 1.
  - A branch held during a freeze is handled in the release cycle and counted once.
- Load-use (third priority): the condition is ex_load & ex_reg_write & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Outputs: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en and mem_wb_en stay 1.
  - This is exactly one bubble; on the next cycle the load is in MEM and the condition clears.
  - If a branch is taken in the same cycle, the branch wins and no stall is taken.
- Default (no hazard): all enables 1 and both flushes 0.
- Forwarding for fwd_a_sel on ex_rs1 (fwd_b_sel uses ex_rs2 identically):
  - 01 if mem_reg_write & !mem_load & mem_rd!=0 & mem_rd==ex_rs1.
  - Otherwise 10 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1.
  - Otherwise 00.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- stall_cycles increments on every cycle with pc_en=0 (freeze, load-use or ERR). flush_count increments per counted branch. Both counters saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Load-use: EX holds lw x5 and ID holds add x6,x5,x1 (id_uses_rs1=1) -> 1 cycle of pc_en=0, if_id_en=0, id_ex_flush=1; the next cycle returns to defaults with stall_cycles=1. The same case with ex_rd=0 -> no stall.
- Forward priority: mem_rd=wb_rd=7 with both reg_writes set and ex_rs1=7 -> fwd_a_sel=01. With mem_load=1 -> 10. With ex_rs2=0 -> fwd_b_sel=00.
- Memory wait: mem_req=1 and dmem_ready low for 3 cycles, then high -> enables are 0 for 3 cycles and all 1 in the 4th; state returns to RUN; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4 and dmem_ready held 0 -> state ERR after 4 wait cycles, mem_err=1, and enables stay 0 until a rst_n pulse clears everything.
- Branch and load-use in the same cycle -> both flushes are 1, pc_en=1, flush_count=1, no stall. A branch during a 2-cycle freeze -> the flush happens in the release cycle and flush_count=1.
- Reset asserted during MEM_WAIT -> the next cycle has the RUN state, counters at 0, and both flushes at 1 while rst_n=0.
